// File: rtl/pwm_a_pos_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_a_pos_pkg
// Purpose  : Shared servo PWM constants and decoder state encoding. The angle
//            generator and the position decoder both draw MIN_WIDTH/STEP from
//            here so encode and decode stay in step.
// Contents : SERVO_* timing constants, max_width() helper, pwm_state_t enum.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_a_pos_pkg;

  localparam int SERVO_MIN_WIDTH   = 25000;    // clocks for POS=0 (0.5 ms @ 50 MHz)
  localparam int SERVO_STEP        = 392;      // clocks per POS LSB
  localparam int SERVO_PERIOD      = 1000000;  // 20 ms frame @ 50 MHz
  localparam int SERVO_LOST_CYCLES = 2000000;  // two frames without a rise
  localparam int SERVO_WIDTH_W     = 17;
  localparam int SERVO_LOST_W      = 21;

  // Widest pulse that still decodes to a legal code (POS=255 plus remainder).
  function automatic int max_width(input int min_w, input int step);
    return min_w + 256 * step - 1;
  endfunction

  localparam int SERVO_MAX_WIDTH = max_width(SERVO_MIN_WIDTH, SERVO_STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } pwm_state_t;

endpackage : pwm_a_pos_pkg
`default_nettype wire

// File: rtl/pwm_a_pos_divisor.sv
`default_nettype none
// ============================================================================
// Module   : pos_divisor
// Purpose  : 8-step restoring divider, rem / STEP -> 8-bit quotient, one
//            quotient bit per cycle starting at the MSB.
// Ports    : clk, rst_n      - clock, async active-low reset
//            i_start         - load i_rem and begin (one cycle)
//            i_rem           - dividend (already offset by MIN_WIDTH)
//            o_q             - quotient, final value valid while o_done=1
//            o_done          - high in the 8th cycle after i_start
// Revision : 1.0 - initial release
// ============================================================================
module pos_divisor
  import pwm_a_pos_pkg::*;
#(
  parameter int STEP    = SERVO_STEP,
  parameter int WIDTH_W = SERVO_WIDTH_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH_W-1:0] i_rem,
  output logic [7:0]         o_q,
  output logic               o_done
);

  // Extra headroom so STEP<<7 never wraps for any legal STEP.
  localparam int DW = WIDTH_W + 8;

  logic [WIDTH_W-1:0] r_rem;
  logic [7:0]         r_q;
  logic [2:0]         r_idx;
  logic               r_busy;

  logic [DW-1:0]      w_sub;
  logic               w_ge;
  logic [WIDTH_W-1:0] w_rem_next;
  logic [7:0]         w_q_next;

  always_comb begin
    w_sub      = DW'(STEP) << r_idx;
    w_ge       = ({8'd0, r_rem} >= w_sub);
    // When w_ge holds, w_sub <= r_rem so its upper bits are zero.
    w_rem_next = w_ge ? (r_rem - w_sub[WIDTH_W-1:0]) : r_rem;
    w_q_next   = r_q | (8'(w_ge) << r_idx);
  end

  // The last bit is folded in combinationally so the result is usable in the
  // same cycle o_done is high.
  assign o_q    = w_q_next;
  assign o_done = r_busy && (r_idx == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_q    <= 8'd0;
      r_idx  <= 3'd0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= i_rem;
      r_q    <= 8'd0;
      r_idx  <= 3'd7;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_q   <= w_q_next;
      if (r_idx == 3'd0) begin
        r_busy <= 1'b0;
      end else begin
        r_idx <= r_idx - 3'd1;
      end
    end
  end

endmodule : pos_divisor
`default_nettype wire

// File: rtl/pwm_a_pos.sv
`default_nettype none
// ============================================================================
// Module   : pwm_a_pos
// Purpose  : Servo PWM pulse-width decoder. Measures the high time of each
//            pulse and converts it back to the 8-bit position code
//            (width = MIN_WIDTH + POS*STEP). Flags out-of-range / stuck-high
//            pulses and loss of signal.
// Ports    : clk          - system clock
//            rst_n        - asynchronous active-low reset
//            i_pwm_in     - asynchronous PWM input
//            o_pos[7:0]   - last decoded position
//            o_valid      - one-cycle pulse when o_pos is updated
//            o_range_err  - one-cycle pulse: short, long or stuck-high pulse
//            o_lost       - level: no rising edge for LOST_CYCLES
// Revision : 1.0 - initial release
// ============================================================================
module pwm_a_pos
  import pwm_a_pos_pkg::*;
#(
  parameter int MIN_WIDTH   = SERVO_MIN_WIDTH,
  parameter int STEP        = SERVO_STEP,
  parameter int WIDTH_W     = SERVO_WIDTH_W,
  parameter int LOST_CYCLES = SERVO_LOST_CYCLES,
  parameter int LOST_W      = SERVO_LOST_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pwm_in,
  output logic [7:0] o_pos,
  output logic       o_valid,
  output logic       o_range_err,
  output logic       o_lost
);

  localparam logic [WIDTH_W-1:0] c_min_width = WIDTH_W'(MIN_WIDTH);
  localparam logic [WIDTH_W-1:0] c_max_width = WIDTH_W'(max_width(MIN_WIDTH, STEP));
  localparam logic [WIDTH_W-1:0] c_cnt_sat   = {WIDTH_W{1'b1}};
  localparam logic [LOST_W-1:0]  c_lost      = LOST_W'(LOST_CYCLES);

  // --------------------------------------------------------------------------
  // Input synchronizer and edge detection
  // --------------------------------------------------------------------------
  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [1:0] r_fill;
  logic       r_armed;
  logic       w_rise;
  logic       w_fall;

  // r_sync2 reads a reset value (0) until the pipeline has refilled. Edges are
  // only trusted once a genuine low has been seen after that, so a pulse that
  // was already high when reset released is never taken as a fresh rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_fill  <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= i_pwm_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_fill != 2'd2) begin
        r_fill <= r_fill + 2'd1;
      end
      if ((r_fill == 2'd2) && !r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_rise = r_armed &  r_sync2 & ~r_prev;
  assign w_fall = r_armed & ~r_sync2 &  r_prev;

  // --------------------------------------------------------------------------
  // Loss-of-signal watchdog
  // --------------------------------------------------------------------------
  logic [LOST_W-1:0] r_wd;
  logic [LOST_W-1:0] w_wd_next;
  logic              r_lost;

  always_comb begin
    if (w_rise) begin
      w_wd_next = '0;
    end else if (r_wd == c_lost) begin
      w_wd_next = r_wd;
    end else begin
      w_wd_next = r_wd + LOST_W'(1);
    end
  end

  // r_lost mirrors (r_wd == c_lost) but comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd   <= '0;
      r_lost <= 1'b0;
    end else begin
      r_wd   <= w_wd_next;
      r_lost <= (w_wd_next == c_lost);
    end
  end

  // --------------------------------------------------------------------------
  // Width measurement FSM
  // --------------------------------------------------------------------------
  pwm_state_t         r_state;
  logic [WIDTH_W-1:0] r_cnt;
  logic [WIDTH_W-1:0] r_width;
  logic [7:0]         r_pos;
  logic               r_valid;
  logic               r_range_err;

  logic               w_div_start;
  logic [WIDTH_W-1:0] w_div_rem;
  logic [7:0]         w_div_q;
  logic               w_div_done;

  // The divider is loaded on the fall cycle straight from the live counter so
  // its 8 steps line up with the 8 CONV cycles. Short pulses wrap here, but
  // their result is overridden by the clamp below.
  assign w_div_start = (r_state == ST_HIGH) && w_fall;
  assign w_div_rem   = r_cnt - c_min_width;

  pos_divisor #(
    .STEP    (STEP),
    .WIDTH_W (WIDTH_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_div_start),
    .i_rem   (w_div_rem),
    .o_q     (w_div_q),
    .o_done  (w_div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_width     <= '0;
      r_pos       <= 8'd0;
      r_valid     <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_range_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_cnt   <= WIDTH_W'(1);
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            r_width <= r_cnt;
            r_state <= ST_CONV;
          end else if (r_cnt == c_cnt_sat) begin
            // Stuck high: abandon the pulse. IDLE needs a new low-to-high.
            r_range_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + WIDTH_W'(1);
          end
        end
        ST_CONV: begin
          if (w_div_done) begin
            r_valid <= 1'b1;
            if (r_width < c_min_width) begin
              r_pos       <= 8'd0;
              r_range_err <= 1'b1;
            end else if (r_width > c_max_width) begin
              r_pos       <= 8'd255;
              r_range_err <= 1'b1;
            end else begin
              r_pos <= w_div_q;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_pos       = r_pos;
  assign o_valid     = r_valid;
  assign o_range_err = r_range_err;
  assign o_lost      = r_lost;

endmodule : pwm_a_pos
`default_nettype wire

// File: tb/tb_pwm_a_pos.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_a_pos
// Purpose  : Directed self-checking bench for pwm_a_pos, run with scaled-down
//            timing (MIN_WIDTH=100, STEP=4, WIDTH_W=11, LOST_CYCLES=3000) so
//            saturation and loss-of-signal are reachable in a short run.
//            MAX width = 100 + 256*4 - 1 = 1123, counter saturates at 2047.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_a_pos;

  logic       clk;
  logic       rst_n;
  logic       pin;
  logic [7:0] o_pos;
  logic       o_valid;
  logic       o_range_err;
  logic       o_lost;

  int total;
  int bad;

  pwm_a_pos #(
    .MIN_WIDTH   (100),
    .STEP        (4),
    .WIDTH_W     (11),
    .LOST_CYCLES (3000),
    .LOST_W      (12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_pwm_in    (pin),
    .o_pos       (o_pos),
    .o_valid     (o_valid),
    .o_range_err (o_range_err),
    .o_lost      (o_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one pulse of n clocks, then watch 40 cycles. VALID is expected once,
  // 11 cycles after the pin falls (2 sync + fall detect + 8 CONV).
  task automatic pulse(input string tag, input int n, input bit glitch,
                       input int exp_pos, input int exp_err);
    int nv = 0;
    int ne = 0;
    int kv = -1;
    int pv = -1;
    int ev = -1;
    pin = 1'b1;
    tick(n);
    pin = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (o_valid === 1'b1) begin
        nv++;
        if (kv < 0) begin
          kv = k;
          pv = int'(o_pos);
          ev = int'(o_range_err);
        end
      end
      if (o_range_err === 1'b1) ne++;
      if (glitch && k == 4)  pin = 1'b1;
      if (glitch && k == 24) pin = 1'b0;
    end
    chk({tag, " valid_count"}, nv, 1);
    chk({tag, " latency"}, kv, 11);
    chk({tag, " pos"}, pv, exp_pos);
    chk({tag, " err_at_valid"}, ev, exp_err);
    chk({tag, " err_count"}, ne, exp_err);
    chk({tag, " pos_hold"}, int'(o_pos), exp_pos);
    tick(200);
  endtask

  initial begin
    int nv;
    int ne;
    int ke;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    pin   = 1'b0;
    tick(3);
    chk("reset pos", int'(o_pos), 0);
    chk("reset valid", int'(o_valid), 0);
    chk("reset err", int'(o_range_err), 0);
    chk("reset lost", int'(o_lost), 0);
    rst_n = 1'b1;
    tick(20);

    // Nominal decode and boundaries.
    pulse("w100",  100,  1'b0, 0,   0);
    pulse("w500",  500,  1'b0, 100, 0);
    pulse("w503",  503,  1'b0, 100, 0);
    pulse("w1120", 1120, 1'b0, 255, 0);
    pulse("w1123", 1123, 1'b0, 255, 0);
    pulse("w1124", 1124, 1'b0, 255, 1);
    pulse("w80",   80,   1'b0, 0,   1);
    pulse("w99",   99,   1'b0, 0,   1);
    pulse("w1500", 1500, 1'b0, 255, 1);

    // Stuck high: counter saturates, then the watchdog trips.
    nv = 0;
    ne = 0;
    ke = -1;
    pin = 1'b1;
    for (int k = 1; k <= 3003; k++) begin
      tick(1);
      if (o_valid === 1'b1) nv++;
      if (o_range_err === 1'b1) begin
        ne++;
        if (ke < 0) ke = k;
      end
      if (k == 3002) chk("lost before limit", int'(o_lost), 0);
    end
    chk("stuck lost", int'(o_lost), 1);
    chk("stuck valid_count", nv, 0);
    chk("stuck err_count", ne, 1);
    chk("stuck err_cycle", ke, 2050);
    pin = 1'b0;
    tick(100);
    chk("lost held", int'(o_lost), 1);
    chk("pos held while lost", int'(o_pos), 255);
    pulse("recover", 500, 1'b0, 100, 0);
    chk("lost cleared", int'(o_lost), 0);

    // Reset in the middle of a pulse.
    nv = 0;
    pin = 1'b1;
    tick(300);
    rst_n = 1'b0;
    #1;
    chk("midrst pos", int'(o_pos), 0);
    chk("midrst valid", int'(o_valid), 0);
    chk("midrst err", int'(o_range_err), 0);
    chk("midrst lost", int'(o_lost), 0);
    tick(5);
    rst_n = 1'b1;
    tick(195);
    pin = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (o_valid === 1'b1 || o_range_err === 1'b1) nv++;
    end
    chk("truncated no output", nv, 0);
    chk("truncated pos", int'(o_pos), 0);
    tick(100);
    pulse("after_rst", 600, 1'b0, 125, 0);

    // Second rise while converting is ignored.
    pulse("glitch", 500, 1'b1, 100, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pwm_a_pos
`default_nettype wire

// File: doc/pwm_a_pos.md
Name: pwm_a_pos

Overview:
Decodes a servo-style PWM pulse train back into the 8-bit position code that our angle generator encodes with width = MIN_WIDTH + POS*STEP. Used on the feedback/loopback path to check the servo drive and to accept position commands from an external PWM source. It measures the high time of each pulse and converts it to POS with an 8-step restoring divider. It also flags out-of-range pulses and loss of signal.

Parameters:
MIN_WIDTH, 25000, pulse width in clocks for POS=0 (0.5 ms at 50 MHz)
STEP, 392, clocks per POS LSB
WIDTH_W, 17, width counter bits
LOST_CYCLES, 2000000, cycles with no rising edge before LOST asserts (two 20 ms frames)
LOST_W, 21, watchdog counter bits

Ports:
CLK  in  1  system clock, 50 MHz
RST_N  in  1  asynchronous active-low reset
PWM_IN  in  1  asynchronous PWM input
POS  out  8  last decoded position
VALID  out  1  one-cycle pulse when POS has been updated
RANGE_ERR  out  1  one-cycle pulse: width below MIN_WIDTH, above MAX_WIDTH, or stuck high
LOST  out  1  level: no rising edge for LOST_CYCLES

Behaviour:
- Reset (RST_N=0, async) forces POS=0, VALID=0, RANGE_ERR=0, LOST=0, synchronizer=0, counters=0, state=IDLE.
- PWM_IN passes through a 2-FF synchronizer. Edges are detected on the synced signal against a registered copy. Rise/fall are seen 3 cycles after the pin changes.
- MAX_WIDTH = MIN_WIDTH + 256*STEP - 1 = 125351.
- States:
  - IDLE: wait for a rise. On a rise, width counter <= 1 and go to HIGH.
  - HIGH: counter +1 each cycle while the synced input is 1.
    - On fall (cycle F), capture the width and go to CONV.
    - If the counter reaches 2^WIDTH_W-1: pulse RANGE_ERR, no VALID, go to IDLE. Re-arming needs a fresh low-to-high transition.
  - CONV: 8 cycles, F+1..F+8, one quotient bit per cycle from MSB.
    - rem = width - MIN_WIDTH.
    - For k=7..0: if rem >= STEP<<k then rem -= STEP<<k and q[k]=1.
    - Width < MIN_WIDTH: result forced to 0 with RANGE_ERR. Width > MAX_WIDTH: result forced to 255 with RANGE_ERR. Compare on the captured width, not on rem.
  - DONE: at the edge ending cycle F+8, POS <= result. VALID=1, plus RANGE_ERR if applicable, during cycle F+9 only. Next state is IDLE.
- Edges during CONV/DONE are ignored. IDLE requires a new rise, so a pulse already in progress is never half-measured.
- Width arithmetic is unsigned WIDTH_W bits. rem never exceeds 100351, so it fits.
- Watchdog:
  - Counter clears on every detected rise and otherwise increments, saturating at LOST_CYCLES.
  - LOST=1 while the counter equals LOST_CYCLES. It clears in the cycle after a rise.
  - POS holds its last value while LOST.
- Reset mid-pulse aborts everything. After reset, the first measured pulse is the first full pulse.

Decomposition:
- Shared package: MIN_WIDTH, STEP, PERIOD (1000000), LOST_CYCLES, WIDTH_W, MAX_WIDTH derivation, and the state enum (IDLE, HIGH, CONV, DONE). The angle generator should use the same MIN_WIDTH/STEP constants.
- One sub-module: pos_divisor.
  - Inputs: start, rem[WIDTH_W-1:0].
  - Outputs: q[7:0], done.
  - Runs the 8-cycle restoring division, with STEP as a parameter.
- Synchronizer, edge detect, FSM, range clamp and watchdog stay in pwm_a_pos.

Test Plan:
1. High for 25000 cycles, then low -> VALID for exactly one cycle 9 cycles after the synced fall; POS=0; RANGE_ERR=0.
2. High for 64200 (25000+100*392), then high for 64591 in the next frame -> POS=100 both times. Then high for 124960 -> POS=255; no RANGE_ERR.
3. High for 20000 -> POS=0 with RANGE_ERR and VALID in the same cycle. Then high for 130000 -> POS=255, RANGE_ERR=1.
4. PWM_IN held high forever -> RANGE_ERR pulse when the counter saturates (131071), no VALID. Watchdog LOST=1 after 2000000 cycles without a rise. A following normal pulse -> LOST=0, then a correct POS.
5. Drop RST_N mid-pulse (asserted at cycle 30000 of a 64200 pulse, released while still high) -> no VALID for the truncated pulse; all outputs 0; the next full pulse decodes correctly.
6. Glitch: a second rise 4 cycles after a fall (during CONV) -> ignored; POS from the first pulse only, VALID once.
